wb_gain: RTL and testbench

White-balance gain stage placed directly after black-level correction in the Bayer ISP pipeline. It multiplies each DVP-timed raw pixel by a per-channel fixed-point gain (R, Gr, Gb, B), then rounds and saturates the result. Gain updates are double-buffered and take effect only at frame boundaries. It also reports how many pixels were clipped in each frame.

---
 rtl/wb_gain_pkg.sv | 21 ++
 rtl/bayer_phase_tracker.sv | 36 +++
 rtl/wb_gain.sv | 142 ++++++++++++++
 tb/tb_wb_gain.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_gain_pkg.sv
// Shared Bayer ISP types: channel enum, CFA format codes and the phase-to-channel mapping.
// Pure declarations, no latency, no flow control.
package wb_gain_pkg;

    typedef enum logic [1:0] {
        CH_R  = 2'd0,
        CH_GR = 2'd1,
        CH_GB = 2'd2,
        CH_B  = 2'd3
    } bayer_ch_t;

    localparam logic [1:0] FMT_RGGB = 2'd0;
    localparam logic [1:0] FMT_GRBG = 2'd1;
    localparam logic [1:0] FMT_GBRG = 2'd2;
    localparam logic [1:0] FMT_BGGR = 2'd3;

    function automatic bayer_ch_t bayer_phase(input logic [1:0] fmt, input logic row, input logic col);
        return bayer_ch_t'(fmt ^ {row, col});
    endfunction

endpackage

// File: rtl/bayer_phase_tracker.sv
// Tracks Bayer row/column phase from DVP syncs; channel is valid in the same cycle as the pixel.
// Zero latency on channel_o, no backpressure (follows href/vsync every cycle).
module bayer_phase_tracker
    import wb_gain_pkg::*;
#(
    parameter int BAYER_FORMAT = 0
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      href_i,
    input  logic      vsync_i,
    output logic      row_o,
    output logic      col_o,
    output bayer_ch_t channel_o
);

    logic href_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            href_d <= 1'b0;
            col_o  <= 1'b0;
            row_o  <= 1'b0;
        end else begin
            href_d <= href_i;
            col_o  <= href_i ? ~col_o : 1'b0;
            if (vsync_i)
                row_o <= 1'b0;
            else if (href_d && !href_i)
                row_o <= ~row_o;
        end
    end

    assign channel_o = bayer_phase(2'(BAYER_FORMAT), row_o, col_o);

endmodule

// File: rtl/wb_gain.sv
// White-balance gain: per-channel fixed-point multiply, round half up, saturate, count clips per frame.
// 2-cycle latency for pixel/href/vsync, 1 pixel/cycle, no backpressure.
module wb_gain
    import wb_gain_pkg::*;
#(
    parameter int BITS         = 8,
    parameter int GAIN_BITS    = 10,
    parameter int GAIN_FRAC    = 6,
    parameter int CNT_BITS     = 24,
    parameter int BAYER_FORMAT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 href_i,
    input  logic                 vsync_i,
    input  logic [BITS-1:0]      pixel_i,
    input  logic [GAIN_BITS-1:0] r_gain_i,
    input  logic [GAIN_BITS-1:0] gr_gain_i,
    input  logic [GAIN_BITS-1:0] gb_gain_i,
    input  logic [GAIN_BITS-1:0] b_gain_i,
    input  logic                 gain_update_i,
    output logic                 gain_ack_o,
    output logic                 href_o,
    output logic                 vsync_o,
    output logic [BITS-1:0]      pixel_o,
    output logic [CNT_BITS-1:0]  clip_count_o
);

    localparam int                   PROD_BITS = BITS + GAIN_BITS;
    localparam logic [GAIN_BITS-1:0] UNITY     = GAIN_BITS'(1) << GAIN_FRAC;
    localparam logic [PROD_BITS:0]   HALF      = (PROD_BITS+1)'(1) << (GAIN_FRAC - 1);
    localparam logic [PROD_BITS:0]   PIX_MAX   = (PROD_BITS+1)'({BITS{1'b1}});
    localparam logic [CNT_BITS-1:0]  CNT_MAX   = {CNT_BITS{1'b1}};

    logic                 ph_row;
    logic                 ph_col;
    bayer_ch_t            ph_ch;
    // Row/col are published for other Bayer stages; this block only needs the channel.
    logic                 unused_phase;

    logic [GAIN_BITS-1:0] staged_gain [4];
    logic [GAIN_BITS-1:0] hold_gain   [4];
    logic [GAIN_BITS-1:0] act_gain    [4];
    logic                 pending;

    logic                 vsync_d1;
    logic                 href_d1;
    logic                 vs_rise;
    logic [PROD_BITS-1:0] prod_q;

    logic [PROD_BITS:0]   rnd_sum;
    logic [PROD_BITS:0]   rnd_val;
    logic                 clip;
    logic [BITS-1:0]      pix_sat;

    logic [CNT_BITS-1:0]  clip_cnt;
    logic [CNT_BITS-1:0]  cnt_inc;

    bayer_phase_tracker #(
        .BAYER_FORMAT (BAYER_FORMAT)
    ) u_phase (
        .clk       (clk),
        .rst_n     (rst_n),
        .href_i    (href_i),
        .vsync_i   (vsync_i),
        .row_o     (ph_row),
        .col_o     (ph_col),
        .channel_o (ph_ch)
    );

    assign unused_phase = ph_row ^ ph_col;

    assign staged_gain[CH_R]  = r_gain_i;
    assign staged_gain[CH_GR] = gr_gain_i;
    assign staged_gain[CH_GB] = gb_gain_i;
    assign staged_gain[CH_B]  = b_gain_i;

    assign vs_rise    = vsync_i && !vsync_d1;
    assign gain_ack_o = rst_n && vs_rise && (pending || gain_update_i);

    // A request landing on the vsync edge wins over an older pending one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_gain <= '{default: UNITY};
            act_gain  <= '{default: UNITY};
            pending   <= 1'b0;
        end else begin
            if (gain_update_i)
                hold_gain <= staged_gain;
            if (vs_rise && gain_update_i) begin
                act_gain <= staged_gain;
                pending  <= 1'b0;
            end else if (vs_rise && pending) begin
                act_gain <= hold_gain;
                pending  <= 1'b0;
            end else if (gain_update_i) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q   <= '0;
            href_d1  <= 1'b0;
            vsync_d1 <= 1'b0;
        end else begin
            prod_q   <= PROD_BITS'(pixel_i) * PROD_BITS'(act_gain[ph_ch]);
            href_d1  <= href_i;
            vsync_d1 <= vsync_i;
        end
    end

    always_comb begin
        rnd_sum = {1'b0, prod_q} + HALF;
        rnd_val = rnd_sum >> GAIN_FRAC;
        clip    = rnd_val > PIX_MAX;
        pix_sat = clip ? {BITS{1'b1}} : rnd_val[BITS-1:0];
        cnt_inc = (href_d1 && clip && clip_cnt != CNT_MAX) ? clip_cnt + CNT_BITS'(1) : clip_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_o      <= '0;
            href_o       <= 1'b0;
            vsync_o      <= 1'b0;
            clip_cnt     <= '0;
            clip_count_o <= '0;
        end else begin
            pixel_o <= pix_sat;
            href_o  <= href_d1;
            vsync_o <= vsync_d1;
            if (vs_rise) begin
                clip_count_o <= cnt_inc;
                clip_cnt     <= '0;
            end else begin
                clip_cnt <= cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_wb_gain.sv
// Randomized + directed bench for wb_gain, RGGB and BGGR instances driven in parallel
// against a frame/line-level reference model.
module tb_wb_gain;

    localparam int GF    = 6;
    localparam int HALFV = 1 << (GF - 1);
    localparam int MAXP  = 255;
    localparam int CMAX  = (1 << 24) - 1;
    localparam int FMTS [2] = '{0, 3};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        href = 1'b0;
    logic        vsync = 1'b0;
    logic        upd = 1'b0;
    logic [7:0]  pix = '0;
    logic [9:0]  sg [4] = '{10'd64, 10'd64, 10'd64, 10'd64};

    logic        ack [2];
    logic        href_q [2];
    logic        vsync_q [2];
    logic [7:0]  pix_q [2];
    logic [23:0] clip_q [2];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int act [4];
    int hold [4];
    bit pending;
    int x, y;
    bit prev_h, prev_v;
    int cnt [2];
    int cnt_out [2];
    int s_pix [2];
    bit s_clip [2];
    bit s_h, s_v;

    always #5 clk = ~clk;

    wb_gain #(.BAYER_FORMAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .href_i(href), .vsync_i(vsync), .pixel_i(pix),
        .r_gain_i(sg[0]), .gr_gain_i(sg[1]), .gb_gain_i(sg[2]), .b_gain_i(sg[3]),
        .gain_update_i(upd), .gain_ack_o(ack[0]), .href_o(href_q[0]), .vsync_o(vsync_q[0]),
        .pixel_o(pix_q[0]), .clip_count_o(clip_q[0])
    );

    wb_gain #(.BAYER_FORMAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .href_i(href), .vsync_i(vsync), .pixel_i(pix),
        .r_gain_i(sg[0]), .gr_gain_i(sg[1]), .gb_gain_i(sg[2]), .b_gain_i(sg[3]),
        .gain_update_i(upd), .gain_ack_o(ack[1]), .href_o(href_q[1]), .vsync_o(vsync_q[1]),
        .pixel_o(pix_q[1]), .clip_count_o(clip_q[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            act[i]  = 1 << GF;
            hold[i] = 1 << GF;
        end
        pending = 0;
        x = 0; y = 0; prev_h = 0; prev_v = 0;
        s_h = 0; s_v = 0;
        for (int f = 0; f < 2; f++) begin
            cnt[f] = 0; cnt_out[f] = 0; s_pix[f] = 0; s_clip[f] = 0;
        end
    endtask

    // Asserts reset away from the clock edge, checks the async clear, releases after two edges.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        href = 0; vsync = 0; upd = 0; pix = '0;
        #1;
        for (int f = 0; f < 2; f++) begin
            check($sformatf("rst_pix%0d", f), pix_q[f], 0);
            check($sformatf("rst_href%0d", f), href_q[f], 0);
            check($sformatf("rst_vsync%0d", f), vsync_q[f], 0);
            check($sformatf("rst_ack%0d", f), ack[f], 0);
            check($sformatf("rst_clip%0d", f), clip_q[f], 0);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One input cycle: drive, check combinational ack, clock, check registered outputs, advance model.
    task automatic step(input bit h, input bit v, input int p, input bit u);
        int ch, r;
        bit vr;
        int cur_pix [2];
        bit cur_clip [2];
        href = h; vsync = v; pix = p[7:0]; upd = u;
        vr = v && !prev_v;
        #1;
        for (int f = 0; f < 2; f++)
            check($sformatf("ack%0d", f), ack[f], vr && (pending || u));
        for (int f = 0; f < 2; f++) begin
            ch = FMTS[f] ^ (((y & 1) << 1) | (x & 1));
            r  = (p * act[ch] + HALFV) / (1 << GF);
            cur_clip[f] = r > MAXP;
            cur_pix[f]  = cur_clip[f] ? MAXP : r;
        end
        @(posedge clk);
        #1;
        for (int f = 0; f < 2; f++) begin
            check($sformatf("pix%0d", f), pix_q[f], s_pix[f]);
            check($sformatf("href%0d", f), href_q[f], s_h);
            check($sformatf("vsync%0d", f), vsync_q[f], s_v);
            if (s_h && s_clip[f] && cnt[f] < CMAX) cnt[f]++;
            if (vr) begin
                cnt_out[f] = cnt[f];
                cnt[f] = 0;
            end
            check($sformatf("clipcnt%0d", f), clip_q[f], cnt_out[f]);
            s_pix[f]  = cur_pix[f];
            s_clip[f] = cur_clip[f];
        end
        s_h = h; s_v = v;
        if (vr && u) begin
            for (int i = 0; i < 4; i++) act[i] = sg[i];
            pending = 0;
        end else if (vr && pending) begin
            for (int i = 0; i < 4; i++) act[i] = hold[i];
            pending = 0;
        end else if (u) begin
            pending = 1;
        end
        if (u) for (int i = 0; i < 4; i++) hold[i] = sg[i];
        x = h ? x + 1 : 0;
        if (v) y = 0;
        else if (prev_h && !h) y ^= 1;
        prev_h = h; prev_v = v;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, $urandom_range(0, 255), 0);
    endtask

    task automatic vs_pulse(input bit u);
        step(0, 1, $urandom_range(0, 255), u);
        step(0, 1, $urandom_range(0, 255), 0);
        idle(3);
    endtask

    task automatic line(input int n, input int p);
        for (int i = 0; i < n; i++) step(1, 0, (p < 0) ? int'($urandom_range(0, 255)) : p, 0);
        idle(3);
    endtask

    task automatic set_gains(input int r, input int gr, input int gb, input int b);
        sg[0] = 10'(r); sg[1] = 10'(gr); sg[2] = 10'(gb); sg[3] = 10'(b);
    endtask

    initial begin
        model_reset();
        do_reset();

        // unity after reset
        vs_pulse(0);
        step(1, 0, 200, 0); step(1, 0, 17, 0); idle(3);

        // rounding, update coincident with vsync rise
        set_gains(96, 64, 64, 64);
        vs_pulse(1);
        step(1, 0, 100, 0); step(1, 0, 0, 0); step(1, 0, 101, 0); step(1, 0, 0, 0); idle(3);

        // phase mapping incl. zero gain
        set_gains(64, 128, 32, 0);
        vs_pulse(1);
        line(4, 40); line(4, 40);

        // saturation and clip count, then a clean frame
        set_gains(128, 128, 128, 128);
        vs_pulse(1);
        repeat (5) step(1, 0, 200, 0);
        step(1, 0, 100, 0); idle(3);
        set_gains(64, 64, 64, 64);
        vs_pulse(1);
        line(4, 100);
        vs_pulse(0);

        // deferred update mid-line
        set_gains(32, 64, 64, 64);
        step(1, 0, 100, 0); step(1, 0, 100, 0); step(1, 0, 100, 1); step(1, 0, 100, 0); idle(3);
        line(4, 100);
        vs_pulse(0);
        line(2, 100);

        // reset mid-line discards the pending update
        set_gains(32, 32, 32, 32);
        step(1, 0, 100, 1); step(1, 0, 100, 0);
        do_reset();
        vs_pulse(0);
        line(2, 100);

        // randomized frames
        for (int fr = 0; fr < 25; fr++) begin
            int nl;
            if ($urandom_range(0, 2) == 0)
                set_gains($urandom_range(0, 1023), $urandom_range(0, 255),
                          $urandom_range(0, 255), $urandom_range(0, 1023));
            vs_pulse(1'($urandom_range(0, 2) == 0));
            nl = $urandom_range(1, 3);
            for (int l = 0; l < nl; l++) begin
                int w;
                w = 2 * $urandom_range(1, 4);
                for (int i = 0; i < w; i++) begin
                    bit u;
                    u = ($urandom_range(0, 9) == 0);
                    if (u)
                        set_gains($urandom_range(0, 1023), $urandom_range(0, 1023),
                                  $urandom_range(0, 1023), $urandom_range(0, 1023));
                    step(1, 0, $urandom_range(0, 255), u);
                end
                idle(3);
            end
        end
        vs_pulse(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
